// File: rtl/pool_sched_pkg.sv
// pool_sched_pkg: sequencer state encodings and datapath defaults shared with the pool engine
package pool_sched_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam int LANES_DEF = 4;
  localparam int DW_DEF = 16;
endpackage

// File: rtl/pool_sched_loop_cnt.sv
// pool_sched_loop_cnt: (g,oh,ow) nested window counter, ow fastest, wraps to zero after the last window
module pool_sched_loop_cnt #(
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [DIM_W-1:0] g_lim,
  input  logic [DIM_W-1:0] h_lim,
  input  logic [DIM_W-1:0] w_lim,
  output logic [DIM_W-1:0] g,
  output logic [DIM_W-1:0] oh,
  output logic [DIM_W-1:0] ow,
  output logic             last
);
  logic ow_end, oh_end;
  assign ow_end = ow == w_lim;
  assign oh_end = oh == h_lim;
  assign last = ow_end && oh_end && g == g_lim;
  // advance one window per step; limits are the last valid index of each level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g <= '0;
      oh <= '0;
      ow <= '0;
    end else if (clr) begin
      g <= '0;
      oh <= '0;
      ow <= '0;
    end else if (step) begin
      ow <= ow_end ? '0 : ow + DIM_W'(1);
      oh <= !ow_end ? oh : oh_end ? '0 : oh + DIM_W'(1);
      g <= !(ow_end && oh_end) ? g : last ? '0 : g + DIM_W'(1);
    end
endmodule

// File: rtl/pool_sched.sv
// pool_sched: layer sequencer issuing 2x2/stride-2 pool windows and writing results back in order
module pool_sched
  import pool_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int DIM_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DIM_W-1:0]    cfg_h,
  input  logic [DIM_W-1:0]    cfg_w,
  input  logic [DIM_W-1:0]    cfg_c,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [DIM_W-1:0]    win_ch,
  output logic [DIM_W-1:0]    win_h,
  output logic [DIM_W-1:0]    win_w,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [LANES*DW-1:0] res_data,
  input  logic                wr_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [LANES*DW-1:0] wr_data
);
  localparam int IF_W = 4;
  logic [2:0] state, nxt;
  logic [DIM_W-1:0] h_q, w_q, c_q, g_lim, h_lim, w_lim;
  logic [DIM_W-1:0] ig, ioh, iow, wg, woh, wow;
  logic [IF_W-1:0] in_flight;
  logic bad, illegal, iss, clr, ilast, unused_wlast;
  assign g_lim = c_q / DIM_W'(LANES) - DIM_W'(1);
  assign h_lim = (h_q >> 1) - DIM_W'(1);
  assign w_lim = (w_q >> 1) - DIM_W'(1);
  assign illegal = h_q == '0 || h_q[0] || w_q == '0 || w_q[0] || c_q == '0 || (c_q % DIM_W'(LANES)) != '0;
  assign busy = state == CHECK || state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign err = done && bad;
  assign win_valid = state == RUN && in_flight < IF_W'(MAX_OUT);
  assign iss = win_valid && win_ready;
  assign clr = state == IDLE && start;
  assign res_ready = wr_ready && (state == RUN || state == DRAIN);
  assign wr_en = res_valid && res_ready;
  assign wr_data = res_data;
  assign win_ch = ig * DIM_W'(LANES);
  assign win_h = ioh << 1;
  assign win_w = iow << 1;
  assign wr_addr = (ADDR_W'(wg) * ADDR_W'(h_q >> 1) + ADDR_W'(woh)) * ADDR_W'(w_q >> 1) + ADDR_W'(wow);
  // layer sequencing: a bad shape skips straight to a done/err pulse
  always_comb
    nxt = state == IDLE  ? (start ? CHECK : IDLE) :
          state == CHECK ? (illegal ? DONE : RUN) :
          state == RUN   ? (iss && ilast ? DRAIN : RUN) :
          state == DRAIN ? (in_flight == '0 ? DONE : DRAIN) : IDLE;
  // state, latched shape and the count of windows issued but not yet written back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      h_q <= '0;
      w_q <= '0;
      c_q <= '0;
      bad <= 1'b0;
      in_flight <= '0;
    end else begin
      state <= nxt;
      if (clr) begin
        h_q <= cfg_h;
        w_q <= cfg_w;
        c_q <= cfg_c;
        bad <= 1'b0;
      end
      if (state == CHECK) bad <= illegal;
      in_flight <= in_flight + IF_W'(iss) - IF_W'(wr_en);
    end
  pool_sched_loop_cnt #(.DIM_W(DIM_W)) u_iss (
    .clk(clk), .rst_n(rst_n), .clr(clr), .step(iss),
    .g_lim(g_lim), .h_lim(h_lim), .w_lim(w_lim),
    .g(ig), .oh(ioh), .ow(iow), .last(ilast)
  );
  pool_sched_loop_cnt #(.DIM_W(DIM_W)) u_wb (
    .clk(clk), .rst_n(rst_n), .clr(clr), .step(wr_en),
    .g_lim(g_lim), .h_lim(h_lim), .w_lim(w_lim),
    .g(wg), .oh(woh), .ow(wow), .last(unused_wlast)
  );
endmodule
